// File: rtl/rgb_led_sequencer_if.sv
// Colour-table load port for rgb_led_sequencer.
// A transfer happens on each clock edge where cfg_valid and cfg_ready are both high.
//   cfg_valid  master->slave  table write request
//   cfg_ready  slave->master  write accepted when valid&ready
//   cfg_slot   master->slave  slot index to write
//   cfg_color  master->slave  {R,G,B} duties, R in MSBs
//   cfg_dwell  master->slave  dwell in PWM periods, 0 = slot unused
interface rgb_led_sequencer_if #(
  parameter int unsigned SLOT_W   = 2,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned DWELL_W  = 16
);
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [SLOT_W-1:0]     cfg_slot;
  logic [3*PWM_BITS-1:0] cfg_color;
  logic [DWELL_W-1:0]    cfg_dwell;

  modport master (output cfg_valid, cfg_slot, cfg_color, cfg_dwell, input cfg_ready);
  modport slave  (input cfg_valid, cfg_slot, cfg_color, cfg_dwell, output cfg_ready);
endinterface

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: plays a table of colour slots (PWM duties + dwell) in a loop
// on an active-low RGB LED, skipping slots whose dwell is 0.
//   clk_in    system clock
//   rst_n     asynchronous active-low reset (clears the table)
//   cfg       table load port (slave side), ready only in IDLE/PAUSE
//   enable    level: 1 = play, 0 = pause
//   stop      pulse: abort to IDLE, keeps table
//   busy      1 in RUN or PAUSE
//   slot_idx  slot currently shown
//   rgb       active-low LED pins, [2]=red [1]=blue [0]=green, registered
module rgb_led_sequencer #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned DWELL_W  = 16,
  parameter int unsigned N_SLOTS  = 4,
  parameter int unsigned SLOT_W   = $clog2(N_SLOTS)
) (
  input  logic                clk_in,
  input  logic                rst_n,
  rgb_led_sequencer_if.slave  cfg,
  input  logic                enable,
  input  logic                stop,
  output logic                busy,
  output logic [SLOT_W-1:0]   slot_idx,
  output logic [2:0]          rgb
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} state_t;

  state_t                r_state;
  logic [3*PWM_BITS-1:0] r_color [N_SLOTS];
  logic [DWELL_W-1:0]    r_dwell [N_SLOTS];
  logic [PWM_BITS-1:0]   r_pwm;
  logic [PRE_W-1:0]      r_pre;
  logic [DWELL_W-1:0]    r_dcnt;
  logic [SLOT_W-1:0]     r_slot;
  logic [2:0]            r_rgb;

  logic                  w_any_used;
  logic [SLOT_W-1:0]     w_first_used;
  logic [SLOT_W-1:0]     w_next_used;
  logic                  w_tick;
  logic                  w_wrap;
  logic                  w_last;
  logic                  w_wr;
  logic [3*PWM_BITS-1:0] w_cur_color;
  logic [DWELL_W-1:0]    w_cur_dwell;
  logic [PWM_BITS-1:0]   w_duty_r;
  logic [PWM_BITS-1:0]   w_duty_g;
  logic [PWM_BITS-1:0]   w_duty_b;

  assign cfg.cfg_ready = (r_state != ST_RUN);
  assign busy          = (r_state != ST_IDLE);
  assign slot_idx      = r_slot;
  assign rgb           = r_rgb;

  // Descending scans so the lowest matching index is the one that sticks.
  always_comb begin
    w_any_used   = 1'b0;
    w_first_used = '0;
    for (int unsigned i = N_SLOTS; i > 0; i--) begin
      if (r_dwell[i-1] != '0) begin
        w_any_used   = 1'b1;
        w_first_used = SLOT_W'(i - 1);
      end
    end
    // Falls back to the current slot when it is the only one in use.
    w_next_used = r_slot;
    for (int unsigned k = N_SLOTS - 1; k >= 1; k--) begin
      if (r_dwell[SLOT_W'(r_slot + k)] != '0)
        w_next_used = SLOT_W'(r_slot + k);
    end
  end

  assign w_cur_color = r_color[r_slot];
  assign w_cur_dwell = r_dwell[r_slot];
  assign w_duty_r    = w_cur_color[3*PWM_BITS-1 -: PWM_BITS];
  assign w_duty_g    = w_cur_color[2*PWM_BITS-1 -: PWM_BITS];
  assign w_duty_b    = w_cur_color[PWM_BITS-1:0];
  assign w_tick      = (r_pre == PRE_W'(PRESCALE - 1));
  assign w_wrap      = w_tick && (r_pwm == '1);
  // A slot cleared while paused counts as finished at the next period end.
  assign w_last      = (w_cur_dwell == '0) || (r_dcnt == w_cur_dwell - DWELL_W'(1));
  assign w_wr        = cfg.cfg_valid && cfg.cfg_ready && !stop;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pwm   <= '0;
      r_pre   <= '0;
      r_dcnt  <= '0;
      r_slot  <= '0;
      r_rgb   <= '1;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
        r_color[i] <= '0;
        r_dwell[i] <= '0;
      end
    end else begin
      r_rgb <= (r_state == ST_RUN) ? {~(r_pwm < w_duty_r), ~(r_pwm < w_duty_b), ~(r_pwm < w_duty_g)}
                                   : 3'b111;
      if (w_wr) begin
        r_color[cfg.cfg_slot] <= cfg.cfg_color;
        r_dwell[cfg.cfg_slot] <= cfg.cfg_dwell;
      end
      if (stop) begin
        r_state <= ST_IDLE;
        r_pwm   <= '0;
        r_pre   <= '0;
        r_dcnt  <= '0;
        r_slot  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (enable && w_any_used) begin
              r_state <= ST_RUN;
              r_slot  <= w_first_used;
              r_pwm   <= '0;
              r_pre   <= '0;
              r_dcnt  <= '0;
            end
          end
          ST_RUN: begin
            if (!enable) begin
              r_state <= ST_PAUSE;
            end else begin
              r_pre <= w_tick ? '0 : PRE_W'(r_pre + 1'b1);
              if (w_tick)
                r_pwm <= r_pwm + 1'b1;
              if (w_wrap) begin
                if (w_last) begin
                  r_dcnt <= '0;
                  r_slot <= w_next_used;
                end else begin
                  r_dcnt <= r_dcnt + 1'b1;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (enable) begin
              if (w_any_used) begin
                r_state <= ST_RUN;
                r_pwm   <= '0;
                r_pre   <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_pwm   <= '0;
                r_pre   <= '0;
                r_dcnt  <= '0;
                r_slot  <= '0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
